gemm_tile_scheduler: RTL
========================

Name: gemm_tile_scheduler

Overview:
Sequences a tiled GEMM (C[M][N] = A[M][K] x B[K][N]) onto one ROWS x COLS systolic array. Walks output tiles and K-slices in a fixed order and issues one tile command at a time over a valid/ready handshake. It then waits for the array's tile-complete pulse and requests drain/writeback of each finished output tile. It sits between the layer-level start/done (e.g. conv1 im2col GEMM: M=3136, N=64, K=147) and the array/stream-A datapath.

Parameters:
ROWS, 16, array rows = M tile height
COLS, 16, array columns = N tile width
K_TILE, 16, K elements per command
M_TOTAL, 3136, GEMM M extent (>=1)
N_TOTAL, 64, GEMM N extent (>=1)
K_TOTAL, 147, GEMM K extent (>=1)
MW, $clog2(M_TOTAL+1), width of M coordinates
NW, $clog2(N_TOTAL+1), width of N coordinates
KW, $clog2(K_TOTAL+1), width of K coordinates

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
start  in  1  begin a GEMM pass; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE next cycle
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at end of pass
cmd_valid  out  1  tile command valid
cmd_ready  in  1  array accepts command
cmd_m_base  out  MW  first row of tile
cmd_n_base  out  NW  first column of tile
cmd_k_base  out  KW  first K index of slice
cmd_m_len  out  $clog2(ROWS+1)  valid rows, 1..ROWS
cmd_n_len  out  $clog2(COLS+1)  valid cols, 1..COLS
cmd_k_len  out  $clog2(K_TILE+1)  K length, 1..K_TILE
cmd_first_k  out  1  clear accumulators before this slice
cmd_last_k  out  1  final slice of this output tile
tile_done  in  1  pulse: array finished the last accepted command
wb_valid  out  1  request drain of finished tile (coords = current cmd_m_base/cmd_n_base)
wb_ready  in  1  writeback accepted

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Loop order: n_tile outermost, m_tile middle, k_tile innermost (B slice reuse across M).
- Tile counts are ceil(X/tile) per dimension. Last-tile length = X - base, clamped to the tile size.
- States: IDLE -> (start) ISSUE -> (cmd_valid&&cmd_ready) WAIT -> (tile_done) next. If !last_k: advance k, go to ISSUE. If last_k: go to WB -> (wb_valid&&wb_ready) advance m/n, k=0. Then ISSUE, or DONE if final tile. DONE -> IDLE after 1 cycle with done=1.
- cmd_* fields are registered and stable while cmd_valid=1 and cmd_ready=0. cmd_valid is asserted only in ISSUE.
- cmd_valid drops the cycle after the handshake. At most one command is outstanding.
- tile_done outside WAIT is ignored. tile_done in the same cycle as the handshake is ignored; it must arrive in WAIT.
- wb_valid is asserted only in WB and held until wb_ready. Coordinates are held through WB.
- cmd_first_k = (k_base==0). cmd_last_k = (k_base+K_TILE >= K_TOTAL).
- Single tile/single slice case (all totals <= tile sizes): one command with first_k=last_k=1, one WB, then done.
- start while busy: ignored. abort has priority over every transition: next cycle IDLE, cmd_valid=wb_valid=0, busy=0, no done pulse.
- Async rst mid-pass: immediate IDLE, outputs 0.
- Latency, start to first cmd_valid: 1 cycle. Last wb handshake to done: 1 cycle.

Optional Feature:
GEMM_SCHED_PERF_EN:
- Enabled: adds 32-bit outputs perf_cmd_stall (cycles in ISSUE with !cmd_ready), perf_wait (cycles in WAIT) and perf_wb_stall (cycles in WB with !wb_ready).
- Counters clear on accepted start and saturate at 2^32-1. They hold their value after done, and are reset by rst.
- Disabled: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Default params, cmd_ready=wb_ready=1, tile_done 3 cycles after each accept -> 7840 commands and 784 WBs; done once; cmd_k_len 16 x9 then 3. First command (0,0,0,first_k=1); last command m_base=3120, n_base=48, k_base=144, k_len=3, last_k=1.
- M=20,N=20,K=20 with ROWS=COLS=K_TILE=16 -> 8 commands; tile (16,16) has m_len=4, n_len=4; k_len sequence 16,4.
- M=N=K=8 -> one command with first_k=last_k=1, lens 8/8/8, one WB, done 1 cycle after wb handshake.
- Random cmd_ready/wb_ready back-pressure (30% high) -> cmd_* stable while stalled; command sequence identical to the no-stall run.
- abort asserted in WAIT at command 5 -> next cycle IDLE, busy=0, no done. A new start restarts at (0,0,0).
- Spurious tile_done in ISSUE/WB, and start while busy -> no state change; sequence unaffected.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks the output tiles and K-slices of a tiled GEMM
// (n outermost, m middle, k innermost) and issues one tile command at a time
// to a ROWS x COLS systolic array. After the array reports tile_done on the
// last K-slice, it requests writeback of that output tile.
// Optional build macro GEMM_SCHED_PERF_EN adds three 32-bit saturating
// performance counters (command stall, wait, writeback stall).
module gemm_tile_scheduler #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int K_TILE  = 16,
  parameter int M_TOTAL = 3136,
  parameter int N_TOTAL = 64,
  parameter int K_TOTAL = 147,
  parameter int MW      = $clog2(M_TOTAL+1),
  parameter int NW      = $clog2(N_TOTAL+1),
  parameter int KW      = $clog2(K_TOTAL+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [MW-1:0]              cmd_m_base,
  output logic [NW-1:0]              cmd_n_base,
  output logic [KW-1:0]              cmd_k_base,
  output logic [$clog2(ROWS+1)-1:0]  cmd_m_len,
  output logic [$clog2(COLS+1)-1:0]  cmd_n_len,
  output logic [$clog2(K_TILE+1)-1:0] cmd_k_len,
  output logic                       cmd_first_k,
  output logic                       cmd_last_k,
  input  logic                       tile_done,
  output logic                       wb_valid,
  input  logic                       wb_ready
`ifdef GEMM_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_cmd_stall,
  output logic [31:0]                perf_wait,
  output logic [31:0]                perf_wb_stall
`endif
);

  localparam int MLW = $clog2(ROWS+1);
  localparam int NLW = $clog2(COLS+1);
  localparam int KLW = $clog2(K_TILE+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [MW-1:0]  m_base_q, m_base_d;
  logic [NW-1:0]  n_base_q, n_base_d;
  logic [KW-1:0]  k_base_q, k_base_d;
  logic [MLW-1:0] m_len_q, m_len_d;
  logic [NLW-1:0] n_len_q, n_len_d;
  logic [KLW-1:0] k_len_q, k_len_d;
  logic           first_k_q, first_k_d;
  logic           last_k_q, last_k_d;

  logic           last_m, last_n;
  logic [31:0]    m_rem_d, n_rem_d, k_rem_d;

  // Current tile is the last one along M / N.
  always_comb begin
    last_m = (32'(m_base_q) + 32'(ROWS)) >= 32'(M_TOTAL);
    last_n = (32'(n_base_q) + 32'(COLS)) >= 32'(N_TOTAL);
  end

  // Next-state and tile/slice coordinate sequencing; abort overrides all.
  always_comb begin
    state_d  = state_q;
    m_base_d = m_base_q;
    n_base_d = n_base_q;
    k_base_d = k_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          m_base_d = '0;
          n_base_d = '0;
          k_base_d = '0;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tile_done) begin
          if (last_k_q) begin
            state_d = S_WB;
          end else begin
            k_base_d = KW'(32'(k_base_q) + 32'(K_TILE));
            state_d  = S_ISSUE;
          end
        end
      end
      S_WB: begin
        if (wb_ready) begin
          if (last_m && last_n) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ISSUE;
            k_base_d = '0;
            if (last_m) begin
              m_base_d = '0;
              n_base_d = NW'(32'(n_base_q) + 32'(COLS));
            end else begin
              m_base_d = MW'(32'(m_base_q) + 32'(ROWS));
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Command fields are computed from the next coordinates so they can be
  // registered; they stay zero until the first pass leaves IDLE.
  always_comb begin
    m_rem_d   = 32'(M_TOTAL) - 32'(m_base_d);
    n_rem_d   = 32'(N_TOTAL) - 32'(n_base_d);
    k_rem_d   = 32'(K_TOTAL) - 32'(k_base_d);
    m_len_d   = '0;
    n_len_d   = '0;
    k_len_d   = '0;
    first_k_d = 1'b0;
    last_k_d  = 1'b0;
    if (state_d != S_IDLE) begin
      m_len_d   = (m_rem_d >= 32'(ROWS))   ? MLW'(ROWS)   : MLW'(m_rem_d);
      n_len_d   = (n_rem_d >= 32'(COLS))   ? NLW'(COLS)   : NLW'(n_rem_d);
      k_len_d   = (k_rem_d >= 32'(K_TILE)) ? KLW'(K_TILE) : KLW'(k_rem_d);
      first_k_d = (k_base_d == '0);
      last_k_d  = (32'(k_base_d) + 32'(K_TILE)) >= 32'(K_TOTAL);
    end
  end

  // State, coordinate and command-field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_base_q  <= '0;
      n_base_q  <= '0;
      k_base_q  <= '0;
      m_len_q   <= '0;
      n_len_q   <= '0;
      k_len_q   <= '0;
      first_k_q <= 1'b0;
      last_k_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_base_q  <= m_base_d;
      n_base_q  <= n_base_d;
      k_base_q  <= k_base_d;
      m_len_q   <= m_len_d;
      n_len_q   <= n_len_d;
      k_len_q   <= k_len_d;
      first_k_q <= first_k_d;
      last_k_q  <= last_k_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign cmd_valid   = (state_q == S_ISSUE);
  assign wb_valid    = (state_q == S_WB);
  assign cmd_m_base  = m_base_q;
  assign cmd_n_base  = n_base_q;
  assign cmd_k_base  = k_base_q;
  assign cmd_m_len   = m_len_q;
  assign cmd_n_len   = n_len_q;
  assign cmd_k_len   = k_len_q;
  assign cmd_first_k = first_k_q;
  assign cmd_last_k  = last_k_q;

`ifdef GEMM_SCHED_PERF_EN
  logic        start_acc;
  logic [31:0] stall_q, wait_q, wbst_q;

  assign start_acc = (state_q == S_IDLE) && start && !abort;

  // Saturating stall/wait counters, cleared on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      wait_q  <= '0;
      wbst_q  <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
      wait_q  <= '0;
      wbst_q  <= '0;
    end else begin
      if ((state_q == S_ISSUE) && !cmd_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if ((state_q == S_WAIT) && (wait_q != '1))                 wait_q  <= wait_q + 32'd1;
      if ((state_q == S_WB) && !wb_ready && (wbst_q != '1))      wbst_q  <= wbst_q + 32'd1;
    end
  end

  assign perf_cmd_stall = stall_q;
  assign perf_wait      = wait_q;
  assign perf_wb_stall  = wbst_q;
`endif

endmodule
